float_mul_pipe: RTL

Parametrised, fully pipelined IEEE-754-style floating-point multiplier for the JPEG datapath (DCT/quantiser scaling). Format width is set by EXP_W/MAN_W, covering fp32 and fp16. It adds full special-value handling, exception flags and valid/ready backpressure. One result per cycle when not stalled; fixed latency.

---
 rtl/float_pkg.sv | 35 +++
 rtl/pipe_reg_en.sv | 28 ++
 rtl/float_mul_pipe.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/float_pkg.sv
// rtl/float_pkg.sv - shared operand classes, flag indices and classifier for the fp multiplier
package float_pkg;

    typedef enum logic [1:0] {
        FC_ZERO = 2'd0,
        FC_NORM = 2'd1,
        FC_INF  = 2'd2,
        FC_NAN  = 2'd3
    } fclass_t;

    localparam int FLG_INVALID   = 3;
    localparam int FLG_OVERFLOW  = 2;
    localparam int FLG_UNDERFLOW = 1;
    localparam int FLG_INEXACT   = 0;

    // Callers zero-extend their fields; exp_w tells which exponent code is all-ones.
    localparam int CLS_EXP_W  = 16;
    localparam int CLS_FRAC_W = 64;

    function automatic fclass_t classify(input logic [CLS_EXP_W-1:0]  exp,
                                         input logic [CLS_FRAC_W-1:0] frac,
                                         input int                    exp_w);
        logic [CLS_EXP_W-1:0] ones;
        fclass_t              cls;
        ones = ~({CLS_EXP_W{1'b1}} << exp_w);
        cls  = FC_NORM;
        if (exp == '0) begin
            cls = FC_ZERO;
        end else if (exp == ones) begin
            cls = (frac == '0) ? FC_INF : FC_NAN;
        end
        return cls;
    endfunction

endpackage

// File: rtl/pipe_reg_en.sv
// rtl/pipe_reg_en.sv - enabled pipeline register: reset valid bit, unreset data
module pipe_reg_en #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             valid_d,
    input  logic [WIDTH-1:0] data_d,
    output logic             valid_q,
    output logic [WIDTH-1:0] data_q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else if (en) begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/float_mul_pipe.sv
// rtl/float_mul_pipe.sv - pipelined IEEE-754-style multiplier with RNE, specials, flags and backpressure
module float_mul_pipe
    import float_pkg::*;
#(
    parameter int EXP_W      = 8,
    parameter int MAN_W      = 23,
    parameter int MUL_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic [EXP_W+MAN_W:0]     din1,
    input  logic [EXP_W+MAN_W:0]     din2,
    input  logic                     din_valid,
    output logic                     din_ready,
    output logic [EXP_W+MAN_W:0]     dout,
    output logic [3:0]               dout_flags,
    output logic                     dout_valid,
    input  logic                     dout_ready
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam int EW   = EXP_W + 2;
    localparam int MW   = MAN_W + 1;
    localparam int PW   = 2 * MW;
    localparam logic signed [EW-1:0] E_MAX = EW'((1 << EXP_W) - 1);

    typedef struct packed {
        logic                 sign;
        fclass_t              c1;
        fclass_t              c2;
        logic signed [EW-1:0] e;
        logic [MW-1:0]        m1;
        logic [MW-1:0]        m2;
    } s1_t;

    typedef struct packed {
        logic                 sign;
        fclass_t              c1;
        fclass_t              c2;
        logic signed [EW-1:0] e;
        logic [PW-1:0]        prod;
    } prod_t;

    typedef struct packed {
        logic                 sign;
        fclass_t              c1;
        fclass_t              c2;
        logic signed [EW-1:0] e;
        logic [MAN_W-1:0]     frac;
        logic                 inexact;
    } rnd_t;

    localparam int S1_BITS   = $bits(s1_t);
    localparam int PROD_BITS = $bits(prod_t);
    localparam int RND_BITS  = $bits(rnd_t);

    logic  stall;
    logic  pipe_en;

    s1_t   s1_d;
    s1_t   s1_q;
    logic  s1_valid_q;
    prod_t prod_d;
    prod_t prod_q [MUL_STAGES];
    logic  prod_valid_q [MUL_STAGES];
    rnd_t  rnd_d;
    rnd_t  rnd_q;
    logic  rnd_valid_q;
    logic [W+3:0] out_d;
    logic [W+3:0] out_q;

    // A stalled output freezes the whole pipe, bubbles included.
    assign stall     = dout_valid & ~dout_ready;
    assign pipe_en   = ~stall;
    assign din_ready = ~stall;

    always_comb begin
        s1_d      = '0;
        s1_d.sign = din1[W-1] ^ din2[W-1];
        s1_d.c1   = classify(CLS_EXP_W'(din1[W-2:MAN_W]), CLS_FRAC_W'(din1[MAN_W-1:0]), EXP_W);
        s1_d.c2   = classify(CLS_EXP_W'(din2[W-2:MAN_W]), CLS_FRAC_W'(din2[MAN_W-1:0]), EXP_W);
        s1_d.e    = EW'(din1[W-2:MAN_W]) + EW'(din2[W-2:MAN_W]) - EW'(BIAS);
        s1_d.m1   = {1'b1, din1[MAN_W-1:0]};
        s1_d.m2   = {1'b1, din2[MAN_W-1:0]};
    end

    pipe_reg_en #(.WIDTH(S1_BITS)) u_s1 (
        .clk     (clk),
        .rst_n   (nrst),
        .en      (pipe_en),
        .valid_d (din_valid & din_ready),
        .data_d  (s1_d),
        .valid_q (s1_valid_q),
        .data_q  (s1_q)
    );

    always_comb begin
        prod_d      = '0;
        prod_d.sign = s1_q.sign;
        prod_d.c1   = s1_q.c1;
        prod_d.c2   = s1_q.c2;
        prod_d.e    = s1_q.e;
        prod_d.prod = PW'(s1_q.m1) * PW'(s1_q.m2);
    end

    // Extra product stages only delay the product so synthesis can retime the multiplier.
    for (genvar i = 0; i < MUL_STAGES; i++) begin : g_mul
        if (i == 0) begin : g_first
            pipe_reg_en #(.WIDTH(PROD_BITS)) u_reg (
                .clk     (clk),
                .rst_n   (nrst),
                .en      (pipe_en),
                .valid_d (s1_valid_q),
                .data_d  (prod_d),
                .valid_q (prod_valid_q[i]),
                .data_q  (prod_q[i])
            );
        end else begin : g_next
            pipe_reg_en #(.WIDTH(PROD_BITS)) u_reg (
                .clk     (clk),
                .rst_n   (nrst),
                .en      (pipe_en),
                .valid_d (prod_valid_q[i-1]),
                .data_d  (prod_q[i-1]),
                .valid_q (prod_valid_q[i]),
                .data_q  (prod_q[i])
            );
        end
    end

    logic [PW-1:0]        rnd_p;
    logic [PW-1:0]        rnd_sh;
    logic [MW-1:0]        rnd_mant;
    logic                 rnd_guard;
    logic                 rnd_sticky;
    logic                 rnd_up;
    logic [MW:0]          rnd_sum;
    logic signed [EW-1:0] rnd_e;

    always_comb begin
        rnd_p      = prod_q[MUL_STAGES-1].prod;
        rnd_sh     = rnd_p[PW-1] ? rnd_p : (rnd_p << 1);
        rnd_e      = prod_q[MUL_STAGES-1].e + EW'(rnd_p[PW-1]);
        rnd_mant   = rnd_sh[PW-1:MW];
        rnd_guard  = rnd_sh[MAN_W];
        rnd_sticky = |rnd_sh[MAN_W-1:0];
        rnd_up     = rnd_guard & (rnd_sticky | rnd_mant[0]);
        rnd_sum    = {1'b0, rnd_mant} + (MW+1)'(rnd_up);

        rnd_d         = '0;
        rnd_d.sign    = prod_q[MUL_STAGES-1].sign;
        rnd_d.c1      = prod_q[MUL_STAGES-1].c1;
        rnd_d.c2      = prod_q[MUL_STAGES-1].c2;
        // Rounding carry-out renormalises by one; the fraction bits come out all zero.
        rnd_d.e       = rnd_e + EW'(rnd_sum[MW]);
        rnd_d.frac    = rnd_sum[MW] ? rnd_sum[MAN_W:1] : rnd_sum[MAN_W-1:0];
        rnd_d.inexact = rnd_guard | rnd_sticky;
    end

    pipe_reg_en #(.WIDTH(RND_BITS)) u_rnd (
        .clk     (clk),
        .rst_n   (nrst),
        .en      (pipe_en),
        .valid_d (prod_valid_q[MUL_STAGES-1]),
        .data_d  (rnd_d),
        .valid_q (rnd_valid_q),
        .data_q  (rnd_q)
    );

    logic signed [EW-1:0] pk_e;
    logic                 pk_nan;
    logic                 pk_inf;
    logic                 pk_zero;
    logic [W-1:0]         pk_word;
    logic [3:0]           pk_flags;

    always_comb begin
        pk_e     = rnd_q.e;
        pk_nan   = (rnd_q.c1 == FC_NAN) || (rnd_q.c2 == FC_NAN)
                || ((rnd_q.c1 == FC_INF) && (rnd_q.c2 == FC_ZERO))
                || ((rnd_q.c1 == FC_ZERO) && (rnd_q.c2 == FC_INF));
        pk_inf   = (rnd_q.c1 == FC_INF) || (rnd_q.c2 == FC_INF);
        pk_zero  = (rnd_q.c1 == FC_ZERO) || (rnd_q.c2 == FC_ZERO);
        pk_flags = '0;
        pk_word  = {rnd_q.sign, pk_e[EXP_W-1:0], rnd_q.frac};

        if (pk_nan) begin
            pk_word               = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            pk_flags[FLG_INVALID] = 1'b1;
        end else if (pk_inf) begin
            pk_word = {rnd_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (pk_zero) begin
            pk_word = {rnd_q.sign, {(W-1){1'b0}}};
        end else if (pk_e >= E_MAX) begin
            pk_word                = {rnd_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            pk_flags[FLG_OVERFLOW] = 1'b1;
            pk_flags[FLG_INEXACT]  = 1'b1;
        end else if (pk_e[EW-1] || (pk_e == '0)) begin
            pk_word                 = {rnd_q.sign, {(W-1){1'b0}}};
            pk_flags[FLG_UNDERFLOW] = 1'b1;
            pk_flags[FLG_INEXACT]   = 1'b1;
        end else begin
            pk_flags[FLG_INEXACT] = rnd_q.inexact;
        end
        out_d = {pk_flags, pk_word};
    end

    pipe_reg_en #(.WIDTH(W + 4)) u_out (
        .clk     (clk),
        .rst_n   (nrst),
        .en      (pipe_en),
        .valid_d (rnd_valid_q),
        .data_d  (out_d),
        .valid_q (dout_valid),
        .data_q  (out_q)
    );

    assign dout       = out_q[W-1:0];
    assign dout_flags = out_q[W+3:W];

endmodule
